// File: rtl/adc_capture_writer.sv
// ---------------------------------------------------------------------------
// adc_capture_writer
//
// Captures a burst of ADC samples after an arm/trigger handshake and writes
// them, two samples per word, into a single-port RAM through an Avalon-MM
// style write port. The low half of each word holds the earlier sample.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : asynchronous, active-high
//   sample_data    : ADC sample, qualified by sample_valid
//   sample_valid   : one sample per high cycle
//   arm            : one-cycle request to arm a capture (latches capture_len)
//   trigger        : level; starts the capture when armed
//   abort          : cancels any arm or capture, returns to idle
//   capture_len    : number of words to capture; 0 means the full RAM
//   ram_address    : RAM word address of the current/last write
//   ram_byteenable : all bytes enabled
//   ram_chipselect : mirrors ram_write
//   ram_write      : one-cycle write strobe
//   ram_writedata  : {second sample, first sample}
//   ram_clken      : RAM clock enable, always asserted
//   busy           : high while armed or capturing
//   done           : sticky completion flag, cleared by arm or abort
//   words_written  : words written in the current capture
// ---------------------------------------------------------------------------
module adc_capture_writer #(
    parameter int ADDR_WIDTH   = 11,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SAMPLE_WIDTH-1:0]   sample_data,
    input  logic                      sample_valid,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic                      abort,
    input  logic [ADDR_WIDTH:0]       capture_len,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [3:0]                ram_byteenable,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [2*SAMPLE_WIDTH-1:0] ram_writedata,
    output logic                      ram_clken,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH:0]       words_written
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int DATA_W = 2 * SAMPLE_WIDTH;
    // Full RAM depth expressed in the word-count width (e.g. 2048 in 12 bits).
    localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        words_q, words_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    phase_q, phase_d;      // 0: expecting low half
    logic [SAMPLE_WIDTH-1:0] low_q, low_d;          // held first sample

    logic                    capturing;
    logic                    accept;
    logic [CNT_W-1:0]        len_req;

    // A length of zero, or anything beyond the RAM depth, captures the
    // whole RAM so the address can never wrap.
    always_comb begin
        len_req = capture_len;
        if (capture_len == '0 || capture_len > MAX_WORDS) begin
            len_req = MAX_WORDS;
        end
    end

    // The trigger cycle itself already counts as a capture cycle, so a
    // sample arriving together with the trigger becomes the first sample.
    // Once the final word has been scheduled (count reached the length)
    // further samples are dropped while the last write drains.
    assign capturing = (state_q == ST_CAPTURE) || (state_q == ST_ARMED && trigger);
    assign accept    = capturing && sample_valid && !abort && (words_q != len_q);

    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        phase_d = phase_q;
        low_d   = low_q;

        if (abort) begin
            // Abort wins over arm; any held half word is thrown away. A write
            // already presented on the bus this cycle is unaffected because
            // it lives in write_q.
            state_d = ST_IDLE;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        len_d   = len_req;
                        words_d = '0;
                        addr_d  = '0;
                        phase_d = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // The count reaches the length on the edge that issues the
                    // final strobe; leaving here one cycle later raises done
                    // the cycle after that write.
                    if (words_q == len_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (accept) begin
                if (!phase_q) begin
                    low_d   = sample_data;
                    phase_d = 1'b1;
                end else begin
                    // Word complete: the strobe goes out next cycle at the
                    // current word index, and the count steps on that edge.
                    write_d = 1'b1;
                    wdata_d = {sample_data, low_q};
                    addr_d  = words_q[ADDR_WIDTH-1:0];
                    words_d = words_q + 1'b1;
                    phase_d = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= MAX_WORDS;
            words_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            phase_q <= 1'b0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            phase_q <= phase_d;
            low_q   <= low_d;
        end
    end

    assign ram_address    = addr_q;
    assign ram_writedata  = wdata_q;
    assign ram_write      = write_q;
    assign ram_chipselect = write_q;
    assign ram_byteenable = 4'b1111;
    assign ram_clken      = 1'b1;
    assign busy           = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done           = (state_q == ST_DONE);
    assign words_written  = words_q;

endmodule

// File: tb/tb_adc_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_writer
//
// Self-checking bench for adc_capture_writer. Expected RAM writes are pushed
// to a queue together with the cycle in which the strobe must appear; every
// clock the bench compares the write port against the head of that queue.
// ---------------------------------------------------------------------------
module tb_adc_capture_writer;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        arm;
    logic        trigger;
    logic        abort;
    logic [11:0] capture_len;
    logic [10:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic        busy;
    logic        done;
    logic [11:0] words_written;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   n_writes;
    exp_t exp_q[$];

    adc_capture_writer #(
        .ADDR_WIDTH  (11),
        .SAMPLE_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .arm           (arm),
        .trigger       (trigger),
        .abort         (abort),
        .capture_len   (capture_len),
        .ram_address   (ram_address),
        .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect),
        .ram_write     (ram_write),
        .ram_writedata (ram_writedata),
        .ram_clken     (ram_clken),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] smp(input int k);
        logic [15:0] v;
        v = 16'(k * 7);
        return v ^ 16'hA5A5;
    endfunction

    task automatic idle_inputs();
        sample_valid = 1'b0;
        sample_data  = '0;
        arm          = 1'b0;
        trigger      = 1'b0;
        abort        = 1'b0;
    endtask

    // The write presented by the currently driven inputs must show up right
    // after the next rising edge.
    task automatic push_exp(input logic [10:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Advance one clock, then check the write port against the scoreboard.
    task automatic step();
        exp_t e;
        logic exp_w;
        @(posedge clk);
        #1;
        cyc++;
        exp_w = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        if (ram_write) n_writes++;
        n_cmp++;
        if (ram_write !== exp_w || ram_chipselect !== exp_w) begin
            n_bad++;
            $display("FAIL strobe cyc=%0d write=%b cs=%b expected=%b",
                     cyc, ram_write, ram_chipselect, exp_w);
        end
        if (exp_w) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (ram_address !== e.addr || ram_writedata !== e.data ||
                ram_byteenable !== 4'b1111) begin
                n_bad++;
                $display("FAIL write_word cyc=%0d got addr=%h data=%h be=%h expected addr=%h data=%h be=f",
                         cyc, ram_address, ram_writedata, ram_byteenable, e.addr, e.data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        capture_len = 12'd0;
        idle_inputs();
        #1;
        n_cmp++;
        if (ram_write !== 1'b0 || ram_chipselect !== 1'b0 || ram_address !== 11'd0 ||
            ram_writedata !== 32'd0 || ram_byteenable !== 4'b1111 || ram_clken !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || words_written !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_values got we=%b cs=%b a=%h d=%h be=%h ce=%b busy=%b done=%b ww=%0d",
                     ram_write, ram_chipselect, ram_address, ram_writedata, ram_byteenable,
                     ram_clken, busy, done, words_written);
        end
        step();
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_clken !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset got busy=%b done=%b clken=%b expected 0 0 1", busy, done, ram_clken);
        end
    endtask

    task automatic test_basic();
        capture_len = 12'd2;
        arm = 1'b1;
        step();
        arm = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || words_written !== 12'd0) begin
            n_bad++;
            $display("FAIL basic_armed got busy=%b done=%b ww=%0d expected 1 0 0", busy, done, words_written);
        end
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h1111;
        step();
        trigger = 1'b0;
        sample_data = 16'h2222; push_exp(11'd0, 32'h2222_1111);
        step();
        sample_data = 16'h3333;
        step();
        sample_data = 16'h4444; push_exp(11'd1, 32'h4444_3333);
        step();
        sample_data = 16'h5555;
        n_cmp++;
        if (done !== 1'b0 || words_written !== 12'd2) begin
            n_bad++;
            $display("FAIL basic_last_write got done=%b ww=%0d expected 0 2", done, words_written);
        end
        step();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_written !== 12'd2) begin
            n_bad++;
            $display("FAIL basic_done got done=%b busy=%b ww=%0d expected 1 0 2", done, busy, words_written);
        end
        for (int i = 0; i < 4; i++) begin
            sample_data = 16'h6000 + 16'(i);
            step();
        end
        idle_inputs();
        n_cmp++;
        if (done !== 1'b1 || words_written !== 12'd2 || ram_address !== 11'd1 ||
            ram_writedata !== 32'h4444_3333) begin
            n_bad++;
            $display("FAIL basic_hold got done=%b ww=%0d a=%h d=%h expected 1 2 001 44443333",
                     done, words_written, ram_address, ram_writedata);
        end
    endtask

    task automatic test_full_ram();
        int w0;
        w0 = n_writes;
        capture_len = 12'd0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int k = 0; k < 4100; k++) begin
            sample_valid = 1'b1;
            sample_data  = smp(k);
            trigger      = (k == 0);
            if (k % 2 == 1 && k < 4096) begin
                push_exp(11'((k - 1) / 2), {smp(k), smp(k - 1)});
            end
            step();
        end
        idle_inputs();
        step();
        n_cmp++;
        if (n_writes - w0 !== 2048) begin
            n_bad++;
            $display("FAIL full_count got %0d writes expected 2048", n_writes - w0);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_written !== 12'd2048 || ram_address !== 11'd2047) begin
            n_bad++;
            $display("FAIL full_end got done=%b busy=%b ww=%0d a=%h expected 1 0 2048 7ff",
                     done, busy, words_written, ram_address);
        end
    endtask

    task automatic test_gapped();
        capture_len = 12'd1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        sample_valid = 1'b1; sample_data = 16'hAAA1;
        step();
        sample_valid = 1'b0;
        step();
        step();
        sample_valid = 1'b1; sample_data = 16'hBBB2; push_exp(11'd0, 32'hBBB2_AAA1);
        step();
        sample_valid = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b1 || words_written !== 12'd1 || ram_address !== 11'd0) begin
            n_bad++;
            $display("FAIL gapped_done got done=%b ww=%0d a=%h expected 1 1 000", done, words_written, ram_address);
        end
        for (int i = 0; i < 6; i++) begin
            sample_valid = (i % 3 == 0);
            sample_data  = 16'hC000 + 16'(i);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre got done=%b expected 1", done);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_from_done got done=%b busy=%b expected 0 0", done, busy);
        end
        capture_len = 12'd4;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h0A01;
        step();
        trigger = 1'b0;
        sample_data = 16'h0A02; push_exp(11'd0, 32'h0A02_0A01);
        step();
        sample_data = 16'h0A03;
        step();
        sample_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_address !== 11'd0) begin
            n_bad++;
            $display("FAIL abort_mid got busy=%b done=%b a=%h expected 0 0 000", busy, done, ram_address);
        end
        // Held third sample must not resurface; idle ignores trigger and samples.
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1; trigger = 1'b1; sample_data = 16'h0B00 + 16'(i);
            step();
        end
        idle_inputs();
        arm = 1'b1; abort = 1'b1;
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_beats_arm got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_arm_while_busy();
        trigger = 1'b1; sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_data = 16'h0E00 + 16'(i);
            step();
        end
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL early_trigger got busy=%b expected 0", busy);
        end
        capture_len = 12'd4;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h1001;
        step();
        trigger = 1'b0;
        sample_data = 16'h1002; push_exp(11'd0, 32'h1002_1001);
        step();
        sample_data = 16'h1003;
        step();
        arm = 1'b1; capture_len = 12'd1;
        sample_data = 16'h1004; push_exp(11'd1, 32'h1004_1003);
        step();
        arm = 1'b0;
        n_cmp++;
        if (words_written !== 12'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL arm_ignored got ww=%0d busy=%b expected 2 1", words_written, busy);
        end
        sample_data = 16'h1005; step();
        sample_data = 16'h1006; push_exp(11'd2, 32'h1006_1005); step();
        sample_data = 16'h1007; step();
        sample_data = 16'h1008; push_exp(11'd3, 32'h1008_1007); step();
        sample_valid = 1'b0;
        step();
        n_cmp++;
        if (done !== 1'b1 || words_written !== 12'd4) begin
            n_bad++;
            $display("FAIL arm_busy_done got done=%b ww=%0d expected 1 4", done, words_written);
        end
        // Trigger in DONE is ignored.
        trigger = 1'b1; sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_data = 16'h1100 + 16'(i);
            step();
        end
        idle_inputs();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_written !== 12'd4) begin
            n_bad++;
            $display("FAIL trigger_in_done got done=%b busy=%b ww=%0d expected 1 0 4", done, busy, words_written);
        end
    endtask

    task automatic test_reset_mid_capture();
        capture_len = 12'd8;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h2001;
        step();
        trigger = 1'b0;
        sample_data = 16'h2002; push_exp(11'd0, 32'h2002_2001);
        step();
        sample_data = 16'h2003;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_write !== 1'b0 || ram_chipselect !== 1'b0 || ram_address !== 11'd0 ||
            ram_writedata !== 32'd0 || ram_byteenable !== 4'b1111 || ram_clken !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || words_written !== 12'd0) begin
            n_bad++;
            $display("FAIL async_reset got we=%b cs=%b a=%h d=%h be=%h ce=%b busy=%b done=%b ww=%0d",
                     ram_write, ram_chipselect, ram_address, ram_writedata, ram_byteenable,
                     ram_clken, busy, done, words_written);
        end
        trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_data = 16'h2100 + 16'(i);
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_data = 16'h2200 + 16'(i);
            step();
        end
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b0 || words_written !== 12'd0) begin
            n_bad++;
            $display("FAIL post_reset_idle got busy=%b ww=%0d expected 0 0", busy, words_written);
        end
        capture_len = 12'd1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 16'h3001;
        step();
        trigger = 1'b0;
        sample_data = 16'h3002; push_exp(11'd0, 32'h3002_3001);
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (done !== 1'b1 || words_written !== 12'd1) begin
            n_bad++;
            $display("FAIL recapture got done=%b ww=%0d expected 1 1", done, words_written);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        n_writes = 0;
        test_reset();
        test_basic();
        test_full_ram();
        test_gapped();
        test_abort();
        test_arm_while_busy();
        test_reset_mid_capture();
        step();
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending writes expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
ADC_CAPTURE_WRITER -- requirements
Module: adc_capture_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set RAM word-address width (2048 words).
REQ-002 Parameter SAMPLE_WIDTH, default 16, SHALL set ADC sample width; two samples pack per 32-bit word.
REQ-003 clk  in  1  SHALL be the single clock; all state on rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high.
REQ-005 sample_data  in  16  SHALL carry the ADC sample, qualified by sample_valid.
REQ-006 sample_valid  in  1  SHALL mark one sample per high cycle.
REQ-007 arm  in  1  SHALL be a one-cycle request to arm a capture.
REQ-008 trigger  in  1  SHALL start capture when armed (level, sampled each cycle).
REQ-009 abort  in  1  SHALL cancel any arm or capture.
REQ-010 capture_len  in  12  SHALL give words to capture, 1..2048; value 0 SHALL mean 2048; latched on arm.
REQ-011 ram_address  out  11  SHALL be the RAM word address.
REQ-012 ram_byteenable  out  4  SHALL be 4'b1111 on every write.
REQ-013 ram_chipselect  out  1  SHALL equal ram_write.
REQ-014 ram_write  out  1  SHALL be a one-cycle write strobe.
REQ-015 ram_writedata  out  32  SHALL be {second sample, first sample}.
REQ-016 ram_clken  out  1  SHALL be constant 1 out of reset.
REQ-017 busy  out  1  SHALL be high in ARMED or CAPTURE.
REQ-018 done  out  1  SHALL be a sticky completion flag.
REQ-019 words_written  out  12  SHALL count words written in the current capture.

Function
REQ-020 FSM states SHALL be IDLE, ARMED, CAPTURE, DONE.
REQ-021 IDLE/DONE + arm -> ARMED; capture_len latched, words_written, address, pack phase and done cleared.
REQ-022 ARMED + trigger -> CAPTURE; a sample_valid in the trigger cycle SHALL be the first captured sample.
REQ-023 Samples outside CAPTURE SHALL be discarded.
REQ-024 In CAPTURE, even-phase sample SHALL be held as low half; odd-phase sample completes the word.
REQ-025 Latency: second sample accepted cycle N -> ram_write high cycle N+1 only, address = current word index, data packed.
REQ-026 ram_address SHALL increment by 1 after each write, starting at 0; words_written SHALL equal writes issued (updated same edge).
REQ-027 After write with words_written reaching latched length -> DONE, done high from the next cycle, no further writes; address SHALL never exceed length-1 (no wrap).
REQ-028 arm while ARMED or CAPTURE SHALL be ignored.
REQ-029 abort in any state SHALL -> IDLE next cycle, done stays/clears to 0, held half-word discarded, a write already scheduled for that cycle SHALL still complete.
REQ-030 abort and arm in same cycle: abort wins.
REQ-031 trigger in IDLE or DONE SHALL be ignored.
REQ-032 Outside write cycles ram_write, ram_chipselect SHALL be 0; ram_writedata and ram_address hold last values.

Reset
REQ-033 On reset: state IDLE, ram_write=0, ram_chipselect=0, ram_address=0, ram_writedata=0, ram_byteenable=4'b1111, ram_clken=1, busy=0, done=0, words_written=0, pack phase even.
REQ-034 Reset asserted mid-capture SHALL abandon the capture with no further write strobes.

Verification
REQ-035 capture_len=2, arm, trigger, samples 0x1111,0x2222,0x3333,0x4444 back-to-back -> writes addr0=0x22221111, addr1=0x44443333, done high 1 cycle after 2nd write, words_written=2.
REQ-036 capture_len=0, continuous samples -> exactly 2048 writes, addresses 0..2047, no 2049th write, done=1.
REQ-037 Samples with sample_valid gapped (1 in 3 cycles), capture_len=1 -> single write one cycle after second valid sample.
REQ-038 Abort after 3 samples with capture_len=4 -> one write (addr0), third sample never written, state IDLE, done=0, busy=0.
REQ-039 Trigger before arm, then arm while busy -> no capture from early trigger; second arm does not reset words_written.
REQ-040 Reset pulsed mid-capture -> all outputs at REQ-033 values asynchronously, no write after release until new arm+trigger.
